// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage RV32I pipeline.
//
// Resolves load-use hazards (one bubble), taken branches/jumps resolved in EX
// (IF/ID + ID/EX flush) and multi-cycle data-memory waits (whole-pipe freeze
// with a timeout that parks the block in HALT until reset).
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   id_rs1/id_rs2            source register fields of the ID instruction
//   id_use_rs1/id_use_rs2    ID instruction actually reads rs1/rs2
//   ex_rd, ex_mem_read       destination and load flag of the EX instruction
//   ex_br_taken              EX instruction redirects the PC this cycle
//   mem_req, mem_ready       MEM-stage access request and completion
//   pc_en, ifid_en, idex_en, exmem_en   pipeline register load enables
//   ifid_flush, idex_flush   synchronous clears (NOP / bubble)
//   err_timeout              sticky memory-timeout error
//   perf_stall_cnt, perf_flush_cnt, perf_wait_cnt
//                            32-bit event counters, present only when the
//                            macro HAZARD_PERF_CNT_EN is defined
//
// Control outputs are Mealy: decoded from the state and the current-cycle
// inputs so they act on the next clock edge.

module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_br_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_en,
    output logic       idex_flush,
    output logic       exmem_en,
    output logic       err_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_wait_cnt
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic load_use;
    logic mem_stall;
    logic stall_evt;
    logic flush_evt;

    // x0 is hardwired to zero, so it never carries a real dependency.
    assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));
    assign mem_stall = mem_req && !mem_ready;

    // State, wait counter and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state and Mealy control decode; priority mem stall > branch > load-use.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exmem_en   = 1'b1;
        stall_evt  = 1'b0;
        flush_evt  = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    state_d  = MEM_WAIT;
                    cnt_d    = CNT_W'(1);
                end else if (ex_br_taken) begin
                    // The ID instruction is squashed, so a load-use on it is moot.
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_evt  = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    stall_evt  = 1'b1;
                end
            end
            MEM_WAIT: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                if (mem_ready) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = HALT;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // HALT (and any unreachable encoding) freezes until reset.
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
            end
        endcase

        // Hold the whole pipe quiet while reset is asserted.
        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b0;
            idex_en    = 1'b0;
            idex_flush = 1'b0;
            exmem_en   = 1'b0;
        end
    end

    assign err_timeout = err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_flush_q, perf_wait_q;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_wait_q  <= '0;
        end else begin
            if (stall_evt) perf_stall_q <= perf_stall_q + 32'd1;
            if (flush_evt) perf_flush_q <= perf_flush_q + 32'd1;
            if (state_q == MEM_WAIT) perf_wait_q <= perf_wait_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
    assign perf_wait_cnt  = perf_wait_q;
`else
    logic unused_evt;
    assign unused_evt = stall_evt ^ flush_evt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the hazard rules.
// Output vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
// exmem_en, err_timeout}.

module tb_pipe_hazard_ctrl;

    localparam int unsigned TO = 4;

    localparam logic [6:0] O_RUN  = 7'b1101010;
    localparam logic [6:0] O_LU   = 7'b0001110;
    localparam logic [6:0] O_BR   = 7'b1111110;
    localparam logic [6:0] O_FRZ  = 7'b0000000;
    localparam logic [6:0] O_HALT = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken, mem_req, mem_ready;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, err_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_wait_cnt;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
        .err_timeout(err_timeout)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
        .perf_wait_cnt(perf_wait_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: pipeline mode, consecutive stalled cycles, sticky error, event tallies.
    int m_mode;      // 0 running, 1 waiting on memory, 2 halted
    int m_stall_len; // stalled cycles in the current memory wait, counting the current one
    bit m_err;
    int m_stalls, m_flushes, m_waits;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] outs();
        return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, err_timeout};
    endfunction

    function automatic bit model_lu();
        return ex_mem_read && (ex_rd != 0) &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    endfunction

    function automatic logic [6:0] model_out();
        if (rst) return O_FRZ;
        if (m_mode == 2) return O_HALT;
        if (m_mode == 1) return O_FRZ;
        if (mem_req && !mem_ready) return O_FRZ;
        if (ex_br_taken) return O_BR;
        if (model_lu()) return O_LU;
        return O_RUN;
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_stall_len = 0; m_err = 0;
        m_stalls = 0; m_flushes = 0; m_waits = 0;
    endfunction

    // Advance the model across one rising edge using the current inputs.
    function automatic void model_step();
        if (m_mode == 0) begin
            if (mem_req && !mem_ready) begin
                m_mode = 1;
                m_stall_len = 1;
            end else if (ex_br_taken) m_flushes++;
            else if (model_lu()) m_stalls++;
        end else if (m_mode == 1) begin
            m_waits++;
            m_stall_len++;
            if (mem_ready) m_mode = 0;
            else if (m_stall_len == TO + 1) begin
                m_mode = 2;
                m_err  = 1;
            end
        end
    endfunction

    task automatic set_in(input int rs1, input int rs2, input bit u1, input bit u2,
                          input int rd, input bit mr, input bit br, input bit req, input bit rdy);
        id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = 5'(rd); ex_mem_read = mr; ex_br_taken = br; mem_req = req; mem_ready = rdy;
    endtask

    // Called 1 time unit after a rising edge with inputs already applied.
    task automatic tick(input string tag);
        #2;
        check(tag, 32'(outs()), 32'(model_out()));
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_k(input string tag, input logic [6:0] k);
        #2;
        check({tag, "_k"}, 32'(outs()), 32'(k));
        tick(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
               $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        #2;
        check("rst_outs", 32'(outs()), 32'(O_FRZ));
        model_reset();
`ifdef HAZARD_PERF_CNT_EN
        check("rst_perf", perf_stall_cnt | perf_flush_cnt | perf_wait_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int halt_cycles;

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        check("reset", 32'(outs()), 32'(O_FRZ));
        rst = 1'b0;

        // Load-use on rs1, then the load leaves EX.
        set_in(5, 0, 1, 0, 5, 1, 0, 0, 0); tick_k("lu_rs1", O_LU);
        set_in(5, 0, 1, 0, 5, 0, 0, 0, 0); tick_k("lu_rs1_after", O_RUN);
        // Load-use on rs2.
        set_in(1, 9, 1, 1, 9, 1, 0, 0, 0); tick_k("lu_rs2", O_LU);
        // x0 never stalls; unused operand never stalls.
        set_in(0, 3, 1, 0, 0, 1, 0, 0, 0); tick_k("x0", O_RUN);
        set_in(2, 7, 1, 0, 7, 1, 0, 0, 0); tick_k("rs2_unused", O_RUN);
        // Branch wins over a concurrent load-use.
        set_in(5, 0, 1, 0, 5, 1, 1, 0, 0); tick_k("br_lu", O_BR);
        // Access completing in the same cycle is not a stall.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1); tick_k("mem_hit", O_RUN);

        // Memory wait: 3 not-ready cycles, then ready; branch pending during the freeze.
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
        tick_k("mw0", O_FRZ); tick_k("mw1", O_FRZ); tick_k("mw2", O_FRZ);
        mem_ready = 1'b1; tick_k("mw3", O_FRZ);
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); tick_k("mw_release_br", O_BR);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); tick_k("mw_run", O_RUN);

        // Timeout: 5 stalled cycles, then sticky error until reset.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) tick_k("to_stall", O_FRZ);
        tick_k("to_halt0", O_HALT);
        mem_ready = 1'b1; tick_k("to_halt1", O_HALT);
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); tick_k("to_after_rst", O_RUN);

        // Event counting: 2 bubbles, 1 flush, 3 wait cycles.
        do_reset();
        set_in(4, 0, 1, 0, 4, 1, 0, 0, 0); tick_k("pc_lu0", O_LU);
        set_in(0, 6, 0, 1, 6, 1, 0, 0, 0); tick_k("pc_lu1", O_LU);
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); tick_k("pc_br", O_BR);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick("pc_w0"); tick("pc_w1"); tick("pc_w2");
        mem_ready = 1'b1; tick("pc_w3");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall", perf_stall_cnt, 32'd2);
        check("perf_flush", perf_flush_cnt, 32'd1);
        check("perf_wait",  perf_wait_cnt,  32'd3);
`endif
        tick("pc_run");

        // Random phase.
        halt_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0 || halt_cycles > 3) begin
                do_reset();
                halt_cycles = 0;
            end
            set_in($urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom), 1'($urandom), $urandom_range(0, 3),
                   ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) == 0),
                   ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 6));
            tick("rand");
            if (m_mode == 2) halt_cycles++;
        end
`ifdef HAZARD_PERF_CNT_EN
        check("rand_perf_stall", perf_stall_cnt, 32'(m_stalls));
        check("rand_perf_flush", perf_flush_cnt, 32'(m_flushes));
        check("rand_perf_wait",  perf_wait_cnt,  32'(m_waits));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
